operand_loader: RTL

Upstream feeder for the approximate multiplier. It accepts a stream of 16-bit operands over a valid/ready handshake and writes them into the multiplier's input memory as A/B pairs. Once a full batch is written, it pulses the multiplier's `Start` and waits for its `Done`. It then signals batch completion and reopens the stream for the next batch. Only one batch is ever in flight.

---
 rtl/operand_loader_if.sv | 30 +++
 rtl/operand_loader.sv | 92 +++++++++
 2 files changed

// File: rtl/operand_loader_if.sv
// Bundle of the operand stream, multiplier input-memory write port and multiplier start/done pins.
// master = the loader side; slave = the upstream source and multiplier environment.
interface operand_loader_if #(
    parameter int n_input = 16,
    parameter int addr_w  = 4
);
    logic               in_valid;
    logic [n_input-1:0] in_data;
    logic               in_ready;
    logic               mem_we;
    logic [addr_w-1:0]  mem_addr;
    logic [n_input-1:0] mem_wdata;
    logic               mult_start;
    logic               mult_done;
    logic               batch_done;
    logic               busy;
    logic [7:0]         batch_cnt;

    modport master (
        input  in_valid, in_data, mult_done,
        output in_ready, mem_we, mem_addr, mem_wdata,
        output mult_start, batch_done, busy, batch_cnt
    );

    modport slave (
        output in_valid, in_data, mult_done,
        input  in_ready, mem_we, mem_addr, mem_wdata,
        input  mult_start, batch_done, busy, batch_cnt
    );
endinterface

// File: rtl/operand_loader.sv
// Streams operands into the multiplier input memory as A/B pairs, then runs one multiply batch.
// Write lands one cycle after the handshake; in_ready is registered and drops for the whole batch run.
module operand_loader #(
    parameter int n_input           = 16,
    parameter int n_multiplications = 8,
    parameter int addr_w            = 4
) (
    input  logic               clk,
    input  logic               rst,
    operand_loader_if.master   bus
);
    typedef enum logic [2:0] {
        st_load,
        st_flush,
        st_start,
        st_wait,
        st_fin
    } state_t;

    localparam logic [addr_w-1:0] last_idx = addr_w'(2 * n_multiplications - 1);

    state_t            state;
    logic [addr_w-1:0] word_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= st_load;
            word_cnt       <= '0;
            bus.in_ready   <= 1'b1;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.mult_start <= 1'b0;
            bus.batch_done <= 1'b0;
            bus.busy       <= 1'b0;
            bus.batch_cnt  <= 8'd0;
        end else begin
            bus.mem_we     <= 1'b0;
            bus.mult_start <= 1'b0;
            bus.batch_done <= 1'b0;

            case (state)
                st_load: begin
                    if (bus.in_valid && bus.in_ready) begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= word_cnt;
                        bus.mem_wdata <= n_input'(bus.in_data);
                        bus.busy      <= 1'b1;
                        // Closing the stream on the last word keeps in_ready a pure function of state.
                        if (word_cnt == last_idx) begin
                            word_cnt     <= '0;
                            bus.in_ready <= 1'b0;
                            state        <= st_flush;
                        end else begin
                            word_cnt <= word_cnt + addr_w'(1);
                        end
                    end
                end

                st_flush: begin
                    bus.mult_start <= 1'b1;
                    state          <= st_start;
                end

                st_start: begin
                    state <= st_wait;
                end

                st_wait: begin
                    if (bus.mult_done) begin
                        bus.batch_done <= 1'b1;
                        bus.batch_cnt  <= bus.batch_cnt + 8'd1;
                        state          <= st_fin;
                    end
                end

                st_fin: begin
                    bus.busy     <= 1'b0;
                    bus.in_ready <= 1'b1;
                    state        <= st_load;
                end

                default: begin
                    word_cnt     <= '0;
                    bus.busy     <= 1'b0;
                    bus.in_ready <= 1'b1;
                    state        <= st_load;
                end
            endcase
        end
    end
endmodule
